ddr_cmd_responder: RTL

//  Command-side responder for the network-attached DDR4 path. Parses RX AXI4-Stream

---
 rtl/ddr_cmd_responder.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ddr_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : ddr_cmd_responder
// Description : Command-side responder for the network-attached DDR4 path.
//               Parses RX AXI4-Stream command packets (write / read), issues
//               one AXI4 burst at a time to the MIG port and returns a
//               response packet on TX (write ack, or read header + data).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   ap_clk, ap_rst_n       clock, asynchronous active-low reset
//   rx_axis_*              command stream in (header beat + write payload)
//   tx_axis_*              response stream out (ack, or read header + data)
//   m_axi_aw*/w*/b*        AXI4 write channels to the DDR controller
//   m_axi_ar*/r*           AXI4 read channels to the DDR controller
//   err_cnt                saturating count of malformed packets / bad resp
// ----------------------------------------------------------------------------
// Header beat: [511:504] opcode, [503:470] byte address, [469:462] beats-1.
// ============================================================================
module ddr_cmd_responder #(
  parameter int ADDR_W = 34,
  parameter int DATA_W = 512,
  parameter int ERR_W  = 16
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                rx_axis_tvalid,
  output logic                rx_axis_tready,
  input  logic                rx_axis_tlast,
  input  logic [DATA_W-1:0]   rx_axis_tdata,
  input  logic [DATA_W/8-1:0] rx_axis_tkeep,
  output logic                tx_axis_tvalid,
  input  logic                tx_axis_tready,
  output logic                tx_axis_tlast,
  output logic [DATA_W-1:0]   tx_axis_tdata,
  output logic [DATA_W/8-1:0] tx_axis_tkeep,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  output logic [ERR_W-1:0]    err_cnt
);

  localparam logic [7:0] OP_WR  = 8'h01;
  localparam logic [7:0] OP_RD  = 8'h02;
  localparam logic [7:0] RSP_WR = 8'h81;
  localparam logic [7:0] RSP_RD = 8'h82;

  // Header field positions, counted down from the top of the beat
  localparam int OP_HI   = DATA_W - 1;
  localparam int ADDR_HI = DATA_W - 9;
  localparam int LEN_HI  = DATA_W - 9 - ADDR_W;
  localparam int BRSP_HI = DATA_W - 17 - ADDR_W;
  localparam int SHORT_B = DATA_W - 19 - ADDR_W;
  localparam int LONG_B  = DATA_W - 20 - ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_AW, S_WR_DATA, S_WR_PAD, S_WR_B, S_WR_RSP,
    S_RD_AR, S_RD_HDR, S_RD_DATA, S_DROP
  } state_t;

  state_t              state, state_nx;
  logic                active;      // low during and one cycle after reset
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          len_q;
  logic [7:0]          cnt;
  logic                short_q, long_q, rerr_seen;
  logic [1:0]          bresp_q;
  logic                hdr_take, cnt_inc, set_short, set_long, b_take, rerr_take, err_inc;
  logic [DATA_W-1:0]   wr_rsp, rd_hdr;
  logic [7:0]          rx_op;

  assign rx_op = rx_axis_tdata[OP_HI -: 8];

  always_comb begin
    wr_rsp = '0;
    wr_rsp[OP_HI -: 8]        = RSP_WR;
    wr_rsp[ADDR_HI -: ADDR_W] = addr_q;
    wr_rsp[LEN_HI -: 8]       = len_q;
    wr_rsp[BRSP_HI -: 2]      = bresp_q;
    wr_rsp[SHORT_B]           = short_q;
    wr_rsp[LONG_B]            = long_q;
    rd_hdr = '0;
    rd_hdr[OP_HI -: 8]        = RSP_RD;
    rd_hdr[ADDR_HI -: ADDR_W] = addr_q;
    rd_hdr[LEN_HI -: 8]       = len_q;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= S_IDLE;
      active    <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      rerr_seen <= 1'b0;
      bresp_q   <= 2'b00;
      err_cnt   <= '0;
    end else begin
      state  <= state_nx;
      active <= 1'b1;
      if (hdr_take) begin
        addr_q    <= rx_axis_tdata[ADDR_HI -: ADDR_W];
        len_q     <= rx_axis_tdata[LEN_HI -: 8];
        cnt       <= '0;
        short_q   <= 1'b0;
        long_q    <= 1'b0;
        rerr_seen <= 1'b0;
        bresp_q   <= 2'b00;
      end
      if (cnt_inc)   cnt       <= cnt + 8'd1;
      if (set_short) short_q   <= 1'b1;
      if (set_long)  long_q    <= 1'b1;
      if (rerr_take) rerr_seen <= 1'b1;
      if (b_take)    bresp_q   <= m_axi_bresp;
      if (err_inc && (err_cnt != {ERR_W{1'b1}}))
        err_cnt <= err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_nx       = state;
    hdr_take       = 1'b0;
    cnt_inc        = 1'b0;
    set_short      = 1'b0;
    set_long       = 1'b0;
    b_take         = 1'b0;
    rerr_take      = 1'b0;
    err_inc        = 1'b0;
    rx_axis_tready = 1'b0;
    tx_axis_tvalid = 1'b0;
    tx_axis_tlast  = 1'b0;
    tx_axis_tdata  = '0;
    m_axi_awvalid  = 1'b0;
    m_axi_wvalid   = 1'b0;
    m_axi_wdata    = '0;
    m_axi_wstrb    = '0;
    m_axi_wlast    = (cnt == len_q);
    m_axi_bready   = 1'b0;
    m_axi_arvalid  = 1'b0;
    m_axi_rready   = 1'b0;
    // Bursts always start on a 64-byte boundary
    m_axi_awaddr   = {addr_q[ADDR_W-1:6], 6'b0};
    m_axi_araddr   = {addr_q[ADDR_W-1:6], 6'b0};
    m_axi_awlen    = len_q;
    m_axi_arlen    = len_q;
    case (state)
      S_IDLE: begin
        rx_axis_tready = active;
        if (active && rx_axis_tvalid) begin
          hdr_take = 1'b1;
          if (rx_op == OP_WR) begin
            if (rx_axis_tlast) err_inc = 1'b1;
            else               state_nx = S_WR_AW;
          end else if (rx_op == OP_RD) begin
            if (rx_axis_tlast) state_nx = S_RD_AR;
            else begin
              state_nx = S_DROP;
              err_inc  = 1'b1;
            end
          end else begin
            err_inc = 1'b1;
            if (!rx_axis_tlast) state_nx = S_DROP;
          end
        end
      end
      S_WR_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nx = S_WR_DATA;
      end
      S_WR_DATA: begin
        // Payload flows straight through; the MIG paces the RX stream
        m_axi_wvalid   = rx_axis_tvalid;
        rx_axis_tready = m_axi_wready;
        m_axi_wdata    = rx_axis_tdata;
        m_axi_wstrb    = rx_axis_tkeep;
        if (rx_axis_tvalid && m_axi_wready) begin
          cnt_inc = 1'b1;
          if (cnt == len_q) begin
            state_nx = S_WR_B;
            if (!rx_axis_tlast) begin
              set_long = 1'b1;
              err_inc  = 1'b1;
            end
          end else if (rx_axis_tlast) begin
            set_short = 1'b1;
            err_inc   = 1'b1;
            state_nx  = S_WR_PAD;
          end
        end
      end
      S_WR_PAD: begin
        // Finish the promised burst with null-strobe beats
        m_axi_wvalid = 1'b1;
        if (m_axi_wready) begin
          cnt_inc = 1'b1;
          if (cnt == len_q) state_nx = S_WR_B;
        end
      end
      S_WR_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          b_take   = 1'b1;
          err_inc  = (m_axi_bresp != 2'b00);
          state_nx = S_WR_RSP;
        end
      end
      S_WR_RSP: begin
        tx_axis_tvalid = 1'b1;
        tx_axis_tlast  = 1'b1;
        tx_axis_tdata  = wr_rsp;
        // An over-long packet still has payload waiting on RX
        if (tx_axis_tready) state_nx = long_q ? S_DROP : S_IDLE;
      end
      S_RD_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nx = S_RD_HDR;
      end
      S_RD_HDR: begin
        tx_axis_tvalid = 1'b1;
        tx_axis_tdata  = rd_hdr;
        if (tx_axis_tready) state_nx = S_RD_DATA;
      end
      S_RD_DATA: begin
        tx_axis_tvalid = m_axi_rvalid;
        tx_axis_tdata  = m_axi_rdata;
        tx_axis_tlast  = m_axi_rlast;
        m_axi_rready   = tx_axis_tready;
        if (m_axi_rvalid && tx_axis_tready) begin
          if ((m_axi_rresp != 2'b00) && !rerr_seen) begin
            err_inc   = 1'b1;
            rerr_take = 1'b1;
          end
          if (m_axi_rlast) state_nx = S_IDLE;
        end
      end
      S_DROP: begin
        rx_axis_tready = 1'b1;
        if (rx_axis_tvalid && rx_axis_tlast) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    tx_axis_tkeep = tx_axis_tvalid ? {(DATA_W/8){1'b1}} : {(DATA_W/8){1'b0}};
  end

endmodule
`default_nettype wire
